cache_line_refill_unit: RTL and testbench
=========================================

// Module: cache_line_refill_unit
// PURPOSE
// - Sits between the cache data-store RAM (line-wide, 1-cycle registered read) and word-wide main memory.
// - On a miss, the controller pulses start. The block optionally writes back the evicted dirty line.
// - It then fetches the new line one word at a time, assembles it and writes the whole line into the RAM in one cycle.
// - Owns one RAM port while busy; the controller must not write that index meanwhile.
// PARAMETERS
// N              32  bits per word
// WORDSPERLINE    2  words per line; power of two, >=2
// ADDRESS_WIDTH  10  RAM index width (lines)
// TAG_WIDTH      16  tag width; OFF=$clog2(WORDSPERLINE); MAW=TAG_WIDTH+ADDRESS_WIDTH+OFF
// PORTS
// clk        in   1               clock, all state on rising edge
// reset      in   1               asynchronous, active-high
// start      in   1               request; sampled only when busy=0
// index      in   ADDRESS_WIDTH   line index for fill and writeback
// fill_tag   in   TAG_WIDTH       tag of line to fetch
// wb_dirty   in   1               1: write back the evicted line first
// wb_tag     in   TAG_WIDTH       tag of evicted line
// busy       out  1               high from cycle after accepted start until cycle after done
// done       out  1               1-cycle pulse, coincident with ram_we
// ram_addr   out  ADDRESS_WIDTH   RAM index
// ram_we     out  1               RAM write enable
// ram_wdata  out  WORDSPERLINE*N  line to write; word k at bits [k*N +: N]
// ram_rdata  in   WORDSPERLINE*N  RAM read data, valid 1 cycle after ram_addr
// mem_req    out  1               memory request
// mem_we     out  1               1 = write, 0 = read
// mem_addr   out  MAW             word address {tag, index, offset}
// mem_wdata  out  N               write word
// mem_ack    in   1               transfer completes on a cycle where mem_req&&mem_ack
// mem_rdata  in   N               read word, valid when mem_ack on a read
// BEHAVIOUR
// - Reset (any time, incl. mid-transfer):
//   - FSM=IDLE; busy, done, ram_we, mem_req and mem_we all 0.
//   - ram_addr, ram_wdata, mem_addr, mem_wdata and the offset counter are 0.
//   - A partial line is discarded and never written.
// - FSM states: IDLE, WB_RD, WB_LAT, WB_XFER, FILL_XFER, FILL_WR.
//   - IDLE: start=1 latches index/fill_tag/wb_dirty/wb_tag. Go to WB_RD if wb_dirty, else FILL_XFER. Offset is cleared.
//   - WB_RD: ram_addr=index, ram_we=0; go to WB_LAT.
//   - WB_LAT: capture ram_rdata into the line buffer; go to WB_XFER.
//   - WB_XFER: mem_req=1, mem_we=1, mem_addr={wb_tag,index,off}, mem_wdata=buffer word[off].
//     - On ack: off++. After the last word, off=0 and go to FILL_XFER.
//   - FILL_XFER: mem_req=1, mem_we=0, mem_addr={fill_tag,index,off}.
//     - On ack: buffer word[off]<=mem_rdata, off++. After the last word, go to FILL_WR.
//   - FILL_WR: ram_we=1, ram_addr=index, ram_wdata=buffer, done=1 for exactly one cycle; go to IDLE.
// - Word order: offset 0 first, ascending. The offset counter wraps to 0 after WORDSPERLINE-1.
// - mem_req stays high across consecutive words of one phase. mem_addr/mem_wdata change only on the edge after an ack.
// - Request stability: while waiting for ack, mem_addr, mem_wdata and mem_we are held stable.
// - Stray acks: mem_ack while mem_req=0 is ignored.
// - Zero-wait-state latency (ack in the first req cycle):
//   - fill only: done at cycle WORDSPERLINE+1 after the start edge.
//   - with writeback: done at 2*WORDSPERLINE+3.
// - start while busy=1 is ignored. start in the same cycle as done (FILL_WR) is ignored.
//   - The next request is accepted from IDLE, i.e. the cycle after done.
// - Outside FILL_WR, ram_we=0. Outside WB_XFER/FILL_XFER, mem_req=0.
// - Registered outputs; no combinational path from mem_ack to mem_req.
// TESTING (N=32, WORDSPERLINE=2, ADDRESS_WIDTH=4, TAG_WIDTH=4)
// - Reset, idle 5 cycles -> all outputs 0, no mem_req, no ram_we.
// - start, index=3, fill_tag=5, wb_dirty=0; ack at once with 0xAAAA0000, 0xAAAA0001:
//   - mem_addr 0x0A6 then 0x0A7.
//   - ram_we at index 3 with ram_wdata=0xAAAA0001_AAAA0000; done at cycle 3.
// - Same request with 2 wait cycles per word -> mem_addr/mem_we held stable during waits; done at cycle 7.
// - wb_dirty=1, wb_tag=9, index=3, RAM[3]=0x22222222_11111111:
//   - Writes 0x11111111@0x126, then 0x22222222@0x127.
//   - Then reads 0x0A6/0x0A7; done at cycle 7.
// - start pulsed while busy and stray mem_ack in IDLE -> no effect; exactly one done.
// - reset asserted after first fill ack -> outputs 0 immediately; no ram_we.
//   - A new fill then completes correctly from offset 0.

Source files
------------

// File: rtl/cache_line_refill_unit.sv
// cache_line_refill_unit
//   Moves one cache line between a line-wide data-store RAM (1-cycle registered
//   read) and word-wide main memory. On a start pulse it optionally writes the
//   evicted dirty line back word by word, then fetches the new line word by word,
//   assembles it and writes it into the RAM in a single cycle.
//
// Ports
//   clk, reset      clock (rising edge) and asynchronous active-high reset
//   start           request, sampled only while idle
//   index           RAM line index used for both writeback and fill
//   fill_tag        tag of the line to fetch
//   wb_dirty        write the evicted line back before fetching
//   wb_tag          tag of the evicted line
//   busy            request in progress
//   done            one-cycle pulse, coincident with ram_we
//   ram_addr/ram_we/ram_wdata/ram_rdata   data-store RAM port
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata   main-memory word port
module cache_line_refill_unit #(
    parameter int N             = 32,
    parameter int WORDSPERLINE  = 2,
    parameter int ADDRESS_WIDTH = 10,
    parameter int TAG_WIDTH     = 16,
    localparam int OFF          = $clog2(WORDSPERLINE),
    localparam int MAW          = TAG_WIDTH + ADDRESS_WIDTH + OFF,
    localparam int LW           = WORDSPERLINE * N
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] index,
    input  logic [TAG_WIDTH-1:0]     fill_tag,
    input  logic                     wb_dirty,
    input  logic [TAG_WIDTH-1:0]     wb_tag,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_we,
    output logic [LW-1:0]            ram_wdata,
    input  logic [LW-1:0]            ram_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [MAW-1:0]           mem_addr,
    output logic [N-1:0]             mem_wdata,
    input  logic                     mem_ack,
    input  logic [N-1:0]             mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_RD,
        S_WB_LAT,
        S_WB_XFER,
        S_FILL_XFER,
        S_FILL_WR
    } state_t;

    state_t                   r_state;
    logic [OFF-1:0]           r_off;
    logic [ADDRESS_WIDTH-1:0] r_index;
    logic [TAG_WIDTH-1:0]     r_fill_tag;
    logic [TAG_WIDTH-1:0]     r_wb_tag;
    logic [LW-1:0]            r_buf;

    logic                     r_busy;
    logic                     r_done;
    logic [ADDRESS_WIDTH-1:0] r_ram_addr;
    logic                     r_ram_we;
    logic [LW-1:0]            r_ram_wdata;
    logic                     r_mem_req;
    logic                     r_mem_we;
    logic [MAW-1:0]           r_mem_addr;
    logic [N-1:0]             r_mem_wdata;

    logic [OFF-1:0]           w_off_nxt;
    logic                     w_last;
    logic [LW-1:0]            w_fill_line;

    // Offset wraps naturally because WORDSPERLINE is a power of two.
    assign w_off_nxt = r_off + OFF'(1);
    assign w_last    = (r_off == OFF'(WORDSPERLINE - 1));

    // Line buffer with the word arriving this cycle merged in, so the final
    // word can go straight into the RAM write without an extra cycle.
    always_comb begin
        w_fill_line = r_buf;
        w_fill_line[int'(r_off) * N +: N] = mem_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_off       <= '0;
            r_index     <= '0;
            r_fill_tag  <= '0;
            r_wb_tag    <= '0;
            r_buf       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_index    <= index;
                        r_fill_tag <= fill_tag;
                        r_wb_tag   <= wb_tag;
                        r_off      <= '0;
                        r_busy     <= 1'b1;
                        r_ram_addr <= index;
                        if (wb_dirty) begin
                            r_state <= S_WB_RD;
                        end else begin
                            r_state    <= S_FILL_XFER;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {fill_tag, index, OFF'(0)};
                        end
                    end
                end
                // RAM is addressed; its registered output appears next cycle.
                S_WB_RD: r_state <= S_WB_LAT;
                S_WB_LAT: begin
                    r_buf       <= ram_rdata;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= {r_wb_tag, r_index, OFF'(0)};
                    r_mem_wdata <= ram_rdata[N-1:0];
                    r_state     <= S_WB_XFER;
                end
                S_WB_XFER: begin
                    if (mem_ack) begin
                        r_off <= w_off_nxt;
                        if (w_last) begin
                            // Request stays up: fill follows back-to-back.
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {r_fill_tag, r_index, OFF'(0)};
                            r_state    <= S_FILL_XFER;
                        end else begin
                            r_mem_addr  <= {r_wb_tag, r_index, w_off_nxt};
                            r_mem_wdata <= r_buf[int'(w_off_nxt) * N +: N];
                        end
                    end
                end
                S_FILL_XFER: begin
                    if (mem_ack) begin
                        r_buf <= w_fill_line;
                        r_off <= w_off_nxt;
                        if (w_last) begin
                            r_mem_req   <= 1'b0;
                            r_ram_we    <= 1'b1;
                            r_done      <= 1'b1;
                            r_ram_addr  <= r_index;
                            r_ram_wdata <= w_fill_line;
                            r_state     <= S_FILL_WR;
                        end else begin
                            r_mem_addr <= {r_fill_tag, r_index, w_off_nxt};
                        end
                    end
                end
                S_FILL_WR: begin
                    r_ram_we <= 1'b0;
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_cache_line_refill_unit.sv
// Testbench for cache_line_refill_unit (N=32, 2 words/line, 4-bit index, 4-bit tag).
// Contains a registered-read RAM model, a main-memory responder with
// configurable wait states, and a transaction-level reference model.
module tb_cache_line_refill_unit;

    localparam int N   = 32;
    localparam int WPL = 2;
    localparam int AW  = 4;
    localparam int TW  = 4;
    localparam int MAW = TW + AW + 1;
    localparam int LW  = WPL * N;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [AW-1:0]  index;
    logic [TW-1:0]  fill_tag;
    logic           wb_dirty;
    logic [TW-1:0]  wb_tag;
    logic           busy;
    logic           done;
    logic [AW-1:0]  ram_addr;
    logic           ram_we;
    logic [LW-1:0]  ram_wdata;
    logic [LW-1:0]  ram_rdata;
    logic           mem_req;
    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [N-1:0]   mem_wdata;
    logic           mem_ack;
    logic [N-1:0]   mem_rdata;

    cache_line_refill_unit #(
        .N(N), .WORDSPERLINE(WPL), .ADDRESS_WIDTH(AW), .TAG_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .index(index),
        .fill_tag(fill_tag), .wb_dirty(wb_dirty), .wb_tag(wb_tag),
        .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // ---------------- data-store RAM model ----------------
    logic [LW-1:0] ram_mem [16];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [LW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) ram_mem[pre_addr] <= pre_data;
        else if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // ---------------- main memory responder ----------------
    typedef struct {
        logic           we;
        logic [MAW-1:0] addr;
        logic [N-1:0]   wdata;
    } xfer_t;

    xfer_t       obs_q[$];
    int          wait_sum = 0;
    int          done_cnt = 0;
    int          we_cnt   = 0;
    int          viol     = 0;
    bit          rand_mode;
    int          fixed_wait;
    bit          stray_en;
    logic [31:0] rd_base;
    logic [31:0] rd_salt;

    function automatic logic [31:0] mem_word(input logic [MAW-1:0] a);
        return rd_base ^ (rd_salt * {23'b0, a}) ^ {31'b0, a[0]};
    endfunction

    function automatic int draw_wait();
        return rand_mode ? int'($urandom_range(0, 3)) : fixed_wait;
    endfunction

    int             wcnt = 0;
    int             cur_wait = 0;
    bit             held = 0;
    logic [MAW-1:0] h_addr;
    logic           h_we;
    logic [N-1:0]   h_wdata;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ram_we) we_cnt++;
        if ((done || ram_we) && (done !== ram_we)) begin
            viol++;
            $display("FAIL done_vs_ram_we: done %b ram_we %b", done, ram_we);
        end
        if (mem_req && !busy) begin
            viol++;
            $display("FAIL req_without_busy: mem_req %b busy %b", mem_req, busy);
        end
        if (mem_req && held &&
            (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata)) begin
            viol++;
            $display("FAIL req_stable: addr %h want %h, we %b want %b, wdata %h want %h",
                     mem_addr, h_addr, mem_we, h_we, mem_wdata, h_wdata);
        end
        if (mem_req) begin
            if (wcnt >= cur_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                obs_q.push_back('{mem_we, mem_addr, mem_wdata});
                wait_sum += wcnt;
                wcnt      = 0;
                cur_wait  = draw_wait();
                held      = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                wcnt++;
                held      = 1;
                h_addr    = mem_addr;
                h_we      = mem_we;
                h_wdata   = mem_wdata;
            end
        end else begin
            mem_ack   = stray_en;
            mem_rdata = $urandom;
            wcnt      = 0;
            cur_wait  = draw_wait();
            held      = 0;
        end
    end

    // ---------------- reference model state ----------------
    logic [LW-1:0] model_ram [16];
    bit            known [16];

    task automatic preload(input logic [AW-1:0] a, input logic [LW-1:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
        model_ram[a] = d;
        known[a] = 1'b1;
    endtask

    // One request: builds the expected transfer list and line from the
    // request fields, runs it, and compares everything observed.
    task automatic run_req(input logic [AW-1:0] idx, input logic [TW-1:0] ftag,
                           input logic dirty, input logic [TW-1:0] wtag, input bit pulse,
                           output int lat, output logic [LW-1:0] line,
                           output logic [MAW-1:0] addr0);
        xfer_t         exp_q[$];
        logic [LW-1:0] eline;
        int            base, ws0, n, nx;
        bit            got;
        if (dirty)
            for (int k = 0; k < WPL; k++)
                exp_q.push_back('{1'b1, {wtag, idx, k[0]}, model_ram[idx][k*N +: N]});
        for (int k = 0; k < WPL; k++) begin
            exp_q.push_back('{1'b0, {ftag, idx, k[0]}, 32'h0});
            eline[k*N +: N] = mem_word({ftag, idx, k[0]});
        end
        nx   = exp_q.size();
        base = obs_q.size();
        ws0  = wait_sum;
        @(negedge clk);
        index = idx; fill_tag = ftag; wb_dirty = dirty; wb_tag = wtag; start = 1'b1;
        n = 0; got = 0;
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            start = pulse && (n == 2 || done);
            got = done;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("latency", 64'(n), 64'(nx + (wait_sum - ws0) + (dirty ? 2 : 0) + 1));
        chk("ram_we", 64'(ram_we), 64'd1);
        chk("ram_addr", 64'(ram_addr), 64'(idx));
        chk("ram_wdata", ram_wdata, eline);
        chk("xfer_count", 64'(obs_q.size() - base), 64'(nx));
        for (int i = 0; i < nx && base + i < obs_q.size(); i++) begin
            chk("xfer_we", 64'(obs_q[base+i].we), 64'(exp_q[i].we));
            chk("xfer_addr", 64'(obs_q[base+i].addr), 64'(exp_q[i].addr));
            if (exp_q[i].we)
                chk("xfer_wdata", 64'(obs_q[base+i].wdata), 64'(exp_q[i].wdata));
        end
        model_ram[idx] = eline;
        known[idx] = 1'b1;
        lat   = n;
        line  = ram_wdata;
        addr0 = (obs_q.size() > base) ? obs_q[base].addr : '0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_pulse_width", 64'(done), 64'd0);
    endtask

    typedef struct {
        logic [AW-1:0]  idx;
        logic [TW-1:0]  ftag;
        logic [TW-1:0]  wtag;
        logic           dirty;
        int             waitc;
        bit             pre;
        logic [LW-1:0]  pre_line;
        int             exp_done;
        logic [MAW-1:0] exp_addr0;
        logic [LW-1:0]  exp_line;
    } vec_t;

    vec_t           tbl [3];
    int             lat, d0, w0, o0;
    logic [LW-1:0]  line;
    logic [MAW-1:0] addr0;
    logic [AW-1:0]  ridx;
    logic           rdirty;

    initial begin
        tbl[0] = '{4'd3, 4'd5, 4'd0, 1'b0, 0, 1'b0, 64'h0, 3, 9'h0A6, 64'hAAAA0001_AAAA0000};
        tbl[1] = '{4'd3, 4'd5, 4'd0, 1'b0, 2, 1'b0, 64'h0, 7, 9'h0A6, 64'hAAAA0001_AAAA0000};
        tbl[2] = '{4'd3, 4'd5, 4'd9, 1'b1, 0, 1'b1, 64'h22222222_11111111, 7, 9'h126,
                   64'hAAAA0001_AAAA0000};
        for (int i = 0; i < 16; i++) begin model_ram[i] = '0; known[i] = 1'b0; end

        reset = 1'b1; start = 1'b0; index = '0; fill_tag = '0; wb_dirty = 1'b0; wb_tag = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        rand_mode = 1'b0; fixed_wait = 0; stray_en = 1'b0;
        rd_base = 32'hAAAA0000; rd_salt = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", ram_wdata, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_no_xfer", 64'(obs_q.size()), 64'd0);

        // Directed table
        for (int t = 0; t < 3; t++) begin
            if (tbl[t].pre) preload(tbl[t].idx, tbl[t].pre_line);
            rand_mode = 1'b0; fixed_wait = tbl[t].waitc;
            rd_base = 32'hAAAA0000; rd_salt = 32'h0;
            run_req(tbl[t].idx, tbl[t].ftag, tbl[t].dirty, tbl[t].wtag, 1'b0, lat, line, addr0);
            chk("tbl_done_cycle", 64'(lat), 64'(tbl[t].exp_done));
            chk("tbl_first_addr", 64'(addr0), 64'(tbl[t].exp_addr0));
            chk("tbl_line", line, tbl[t].exp_line);
        end

        // Stray acks while idle
        o0 = obs_q.size(); d0 = done_cnt;
        @(negedge clk) stray_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stray_mem_req", 64'(mem_req), 64'd0);
            chk("stray_busy", 64'(busy), 64'd0);
        end
        stray_en = 1'b0;
        chk("stray_no_xfer", 64'(obs_q.size() - o0), 64'd0);
        chk("stray_no_done", 64'(done_cnt - d0), 64'd0);

        // start pulsed while busy and on the done cycle
        d0 = done_cnt; fixed_wait = 2; rd_base = 32'h5A5A0000; rd_salt = 32'h3;
        run_req(4'd7, 4'd2, 1'b0, 4'd0, 1'b1, lat, line, addr0);
        repeat (4) begin
            @(negedge clk);
            chk("ignored_start_req", 64'(mem_req), 64'd0);
        end
        chk("ignored_start_one_done", 64'(done_cnt - d0), 64'd1);

        // Reset after first fill ack
        fixed_wait = 0; w0 = we_cnt; d0 = done_cnt; o0 = obs_q.size();
        @(negedge clk);
        index = 4'd3; fill_tag = 4'd5; wb_dirty = 1'b0; wb_tag = 4'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_mem_req", 64'(mem_req), 64'd0);
        chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("mid_rst_ram_we", 64'(ram_we), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        chk("mid_rst_one_ack", 64'(obs_q.size() - o0), 64'd1);
        chk("mid_rst_no_write", 64'(we_cnt - w0), 64'd0);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        rd_base = 32'h0BAD0000; rd_salt = 32'h0;
        run_req(4'd3, 4'd5, 1'b0, 4'd0, 1'b0, lat, line, addr0);
        chk("post_rst_first_addr", 64'(addr0), 64'h0A6);

        // Randomized requests with random wait states
        rand_mode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            ridx = 4'($urandom_range(0, 15));
            rdirty = 1'($urandom_range(0, 1));
            if ((rdirty && !known[ridx]) || $urandom_range(0, 3) == 0)
                preload(ridx, {$urandom, $urandom});
            rd_base = $urandom; rd_salt = $urandom | 32'h1;
            run_req(ridx, 4'($urandom_range(0, 15)), rdirty, 4'($urandom_range(0, 15)),
                    1'b0, lat, line, addr0);
        end

        chk("protocol_violations", 64'(viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
